// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular bundle FIFO between 2-wide fetch and decode, flushed on mispredict
// Optional same-cycle empty-queue bypass to decode is enabled by defining FQ_BYPASS_EN.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mispredict,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [XLEN-1:0]          enq_pc,
  input  logic [ILEN-1:0]          enq_inst1,
  input  logic [ILEN-1:0]          enq_inst2,
  input  logic                     enq_slot_valid1,
  input  logic                     enq_slot_valid2,
  input  logic                     enq_pred_taken1,
  input  logic                     enq_pred_taken2,
  input  logic [XLEN-1:0]          enq_pred_target1,
  input  logic [XLEN-1:0]          enq_pred_target2,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [ILEN-1:0]          deq_inst1,
  output logic [ILEN-1:0]          deq_inst2,
  output logic                     deq_slot_valid1,
  output logic                     deq_slot_valid2,
  output logic                     deq_pred_taken1,
  output logic                     deq_pred_taken2,
  output logic [XLEN-1:0]          deq_pred_target1,
  output logic [XLEN-1:0]          deq_pred_target2,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_q      [DEPTH];
  logic [ILEN-1:0] inst1_q   [DEPTH];
  logic [ILEN-1:0] inst2_q   [DEPTH];
  logic            sv1_q     [DEPTH];
  logic            sv2_q     [DEPTH];
  logic            pt1_q     [DEPTH];
  logic            pt2_q     [DEPTH];
  logic [XLEN-1:0] tgt1_q    [DEPTH];
  logic [XLEN-1:0] tgt2_q    [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic full;
  logic empty;
  logic storable;
  logic kill2;
  logic w_sv2;
  logic w_pt2;
  logic bypass;
  logic push;
  logic pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign storable = enq_slot_valid1 | enq_slot_valid2;

  // A predicted-taken slot 1 makes slot 2 wrong-path; its data is kept but marked invalid.
  assign kill2 = enq_slot_valid1 & enq_pred_taken1;
  assign w_sv2 = enq_slot_valid2 & ~kill2;
  assign w_pt2 = enq_pred_taken2 & ~kill2;

`ifdef FQ_BYPASS_EN
  assign bypass = empty & enq_valid & deq_ready & storable & ~mispredict;
`else
  assign bypass = 1'b0;
`endif

  assign enq_ready = ~full;
  assign push      = enq_valid & ~full & ~mispredict & storable & ~bypass;
  assign pop       = deq_ready & ~empty & ~mispredict;
  assign deq_valid = (~empty & ~mispredict) | bypass;
  assign fq_count  = count;

  assign deq_pc           = bypass ? enq_pc           : pc_q[rd_ptr];
  assign deq_inst1        = bypass ? enq_inst1        : inst1_q[rd_ptr];
  assign deq_inst2        = bypass ? enq_inst2        : inst2_q[rd_ptr];
  assign deq_slot_valid1  = bypass ? enq_slot_valid1  : sv1_q[rd_ptr];
  assign deq_slot_valid2  = bypass ? w_sv2            : sv2_q[rd_ptr];
  assign deq_pred_taken1  = bypass ? enq_pred_taken1  : pt1_q[rd_ptr];
  assign deq_pred_taken2  = bypass ? w_pt2            : pt2_q[rd_ptr];
  assign deq_pred_target1 = bypass ? enq_pred_target1 : tgt1_q[rd_ptr];
  assign deq_pred_target2 = bypass ? enq_pred_target2 : tgt2_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        inst1_q[i] <= '0;
        inst2_q[i] <= '0;
        sv1_q[i]   <= 1'b0;
        sv2_q[i]   <= 1'b0;
        pt1_q[i]   <= 1'b0;
        pt2_q[i]   <= 1'b0;
        tgt1_q[i]  <= '0;
        tgt2_q[i]  <= '0;
      end
    end else if (mispredict) begin
      // Flush only rewinds the pointers; stale entry contents are never observable.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= enq_pc;
        inst1_q[wr_ptr] <= enq_inst1;
        inst2_q[wr_ptr] <= enq_inst2;
        sv1_q[wr_ptr]   <= enq_slot_valid1;
        sv2_q[wr_ptr]   <= w_sv2;
        pt1_q[wr_ptr]   <= enq_pred_taken1;
        pt2_q[wr_ptr]   <= w_pt2;
        tgt1_q[wr_ptr]  <= enq_pred_target1;
        tgt2_q[wr_ptr]  <= enq_pred_target2;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed check of fetch_queue against a queue-based model
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst1;
    logic [ILEN-1:0] inst2;
    logic            sv1;
    logic            sv2;
    logic            pt1;
    logic            pt2;
    logic [XLEN-1:0] t1;
    logic [XLEN-1:0] t2;
  } bundle_t;

  logic            clk = 1'b0;
  logic            reset, mispredict, enq_valid, enq_ready, deq_valid, deq_ready;
  logic [XLEN-1:0] enq_pc, enq_pred_target1, enq_pred_target2;
  logic [ILEN-1:0] enq_inst1, enq_inst2;
  logic            enq_slot_valid1, enq_slot_valid2, enq_pred_taken1, enq_pred_taken2;
  logic [XLEN-1:0] deq_pc, deq_pred_target1, deq_pred_target2;
  logic [ILEN-1:0] deq_inst1, deq_inst2;
  logic            deq_slot_valid1, deq_slot_valid2, deq_pred_taken1, deq_pred_taken2;
  logic [$clog2(DEPTH):0] fq_count;

  int vectors = 0;
  int miscompares = 0;
  bundle_t model_q[$];
  bit model_ok = 0;
  bit exp_valid, exp_byp;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mispredict(mispredict),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_inst1(enq_inst1), .enq_inst2(enq_inst2),
    .enq_slot_valid1(enq_slot_valid1), .enq_slot_valid2(enq_slot_valid2),
    .enq_pred_taken1(enq_pred_taken1), .enq_pred_taken2(enq_pred_taken2),
    .enq_pred_target1(enq_pred_target1), .enq_pred_target2(enq_pred_target2),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_inst1(deq_inst1), .deq_inst2(deq_inst2),
    .deq_slot_valid1(deq_slot_valid1), .deq_slot_valid2(deq_slot_valid2),
    .deq_pred_taken1(deq_pred_taken1), .deq_pred_taken2(deq_pred_taken2),
    .deq_pred_target1(deq_pred_target1), .deq_pred_target2(deq_pred_target2),
    .fq_count(fq_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bundle_t enq_bundle();
    bundle_t b;
    bit kill;
    kill    = enq_slot_valid1 && enq_pred_taken1;
    b.pc    = enq_pc;
    b.inst1 = enq_inst1;
    b.inst2 = enq_inst2;
    b.sv1   = enq_slot_valid1;
    b.sv2   = enq_slot_valid2 && !kill;
    b.pt1   = enq_pred_taken1;
    b.pt2   = enq_pred_taken2 && !kill;
    b.t1    = enq_pred_target1;
    b.t2    = enq_pred_target2;
    return b;
  endfunction

  function automatic bit storable();
    return enq_slot_valid1 || enq_slot_valid2;
  endfunction

  task automatic idle_inputs();
    reset = 0; mispredict = 0; enq_valid = 0; deq_ready = 0;
    enq_pc = '0; enq_inst1 = '0; enq_inst2 = '0;
    enq_slot_valid1 = 0; enq_slot_valid2 = 0; enq_pred_taken1 = 0; enq_pred_taken2 = 0;
    enq_pred_target1 = '0; enq_pred_target2 = '0;
  endtask

  task automatic set_bundle(input logic [XLEN-1:0] pc, input bit sv1, input bit sv2);
    enq_valid = 1; enq_pc = pc; enq_slot_valid1 = sv1; enq_slot_valid2 = sv2;
    enq_inst1 = pc ^ 32'h0000_0013; enq_inst2 = pc ^ 32'h0010_0093;
    enq_pred_taken1 = 0; enq_pred_taken2 = 0;
    enq_pred_target1 = pc + 32'h40; enq_pred_target2 = pc + 32'h80;
  endtask

  // Compare DUT outputs, mid-cycle, against what the model says they must be.
  task automatic half();
    bundle_t eb;
    @(negedge clk);
`ifdef FQ_BYPASS_EN
    exp_byp = (model_q.size() == 0) && enq_valid && deq_ready && storable() && !mispredict;
`else
    exp_byp = 0;
`endif
    exp_valid = !mispredict && ((model_q.size() > 0) || exp_byp);
    if (model_ok) begin
      chk("deq_valid", 64'(deq_valid), 64'(exp_valid));
      chk("enq_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
      chk("fq_count", 64'(fq_count), 64'(model_q.size()));
      if (exp_valid) begin
        eb = (model_q.size() > 0) ? model_q[0] : enq_bundle();
        chk("deq_pc", 64'(deq_pc), 64'(eb.pc));
        chk("deq_inst1", 64'(deq_inst1), 64'(eb.inst1));
        chk("deq_inst2", 64'(deq_inst2), 64'(eb.inst2));
        chk("deq_slot_valid", 64'({deq_slot_valid1, deq_slot_valid2}), 64'({eb.sv1, eb.sv2}));
        chk("deq_pred_taken", 64'({deq_pred_taken1, deq_pred_taken2}), 64'({eb.pt1, eb.pt2}));
        chk("deq_pred_target1", 64'(deq_pred_target1), 64'(eb.t1));
        chk("deq_pred_target2", 64'(deq_pred_target2), 64'(eb.t2));
      end
    end
  endtask

  task automatic fin();
    if (reset || mispredict) begin
      model_q.delete();
    end else if (!exp_byp) begin
      bit room;
      room = model_q.size() < DEPTH;
      if (deq_ready && exp_valid) void'(model_q.pop_front());
      if (enq_valid && room && storable()) model_q.push_back(enq_bundle());
    end
    if (reset) model_ok = 1;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    half();
    fin();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    tick();
    idle_inputs();

    // Reset state
    half();
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_fq_count", 64'(fq_count), 64'd0);
    chk("rst_deq_fields", {deq_pc, deq_inst1}, 64'd0);
    chk("rst_deq_fields2", {deq_inst2, deq_pred_target1}, 64'd0);
    chk("rst_deq_fields3", {31'd0, deq_pred_target2, deq_slot_valid1},
        64'({deq_slot_valid2, deq_pred_taken1, deq_pred_taken2}));
    fin();

    // 1: single push, visible next cycle, popped the cycle after
    set_bundle(32'h0, 1, 1);
    enq_inst1 = 32'h0000_0013; enq_inst2 = 32'h0010_0093;
    tick();
    idle_inputs(); deq_ready = 1;
    half();
    chk("t1_deq_valid", 64'(deq_valid), 64'd1);
    chk("t1_deq_pc", 64'(deq_pc), 64'h0);
    chk("t1_deq_inst2", 64'(deq_inst2), 64'h0010_0093);
    chk("t1_fq_count", 64'(fq_count), 64'd1);
    fin();
    idle_inputs();
    half(); chk("t1_count_after_pop", 64'(fq_count), 64'd0); fin();

    // 2: fill to full, overflow push ignored, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      set_bundle(32'(i * 8), 1, 1);
      tick();
    end
    set_bundle(32'h40, 1, 1);
    half();
    chk("t2_enq_ready_full", 64'(enq_ready), 64'd0);
    chk("t2_fq_count_full", 64'(fq_count), 64'd8);
    fin();
    idle_inputs(); deq_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      half(); chk("t2_drain_pc", 64'(deq_pc), 64'(i * 8)); fin();
    end
    half(); chk("t2_empty_deq_valid", 64'(deq_valid), 64'd0); fin();

    // 3: steady count 3 with simultaneous push/pop, pointers wrapping
    idle_inputs();
    for (int i = 0; i < 3; i++) begin set_bundle(32'h100 + 32'(i * 8), 1, 1); tick(); end
    for (int i = 3; i < 13; i++) begin
      set_bundle(32'h100 + 32'(i * 8), 1, 1); deq_ready = 1;
      half();
      chk("t3_fq_count", 64'(fq_count), 64'd3);
      chk("t3_deq_pc", 64'(deq_pc), 64'(32'h100 + 32'((i - 3) * 8)));
      fin();
    end

    // 4: mispredict flush with a concurrent push
    idle_inputs();
    for (int i = 0; i < 2; i++) begin set_bundle(32'h180 + 32'(i * 8), 1, 0); tick(); end
    set_bundle(32'h200, 1, 1); mispredict = 1; deq_ready = 1;
    half();
    chk("t4_count_before", 64'(fq_count), 64'd5);
    chk("t4_deq_valid_mp", 64'(deq_valid), 64'd0);
    fin();
    idle_inputs();
    half();
    chk("t4_count_after", 64'(fq_count), 64'd0);
    chk("t4_deq_valid_after", 64'(deq_valid), 64'd0);
    fin();

    // 5: slot kill on predicted-taken slot 1, then an all-invalid bundle
    set_bundle(32'h300, 1, 1);
    enq_pred_taken1 = 1; enq_pred_target1 = 32'h100; enq_pred_taken2 = 1;
    tick();
    idle_inputs(); deq_ready = 1;
    half();
    chk("t5_slot_valid2", 64'(deq_slot_valid2), 64'd0);
    chk("t5_pred_taken2", 64'(deq_pred_taken2), 64'd0);
    chk("t5_pred_target1", 64'(deq_pred_target1), 64'h100);
    fin();
    idle_inputs();
    set_bundle(32'h308, 0, 0);
    tick();
    idle_inputs();
    half(); chk("t5_empty_bundle_count", 64'(fq_count), 64'd0); fin();

    // 6: push into empty queue while decode is ready
    set_bundle(32'h80, 1, 1); deq_ready = 1;
    half();
`ifdef FQ_BYPASS_EN
    chk("t6_byp_valid", 64'(deq_valid), 64'd1);
    chk("t6_byp_pc", 64'(deq_pc), 64'h80);
    fin();
    idle_inputs();
    half(); chk("t6_byp_count", 64'(fq_count), 64'd0); fin();
`else
    chk("t6_same_cycle_valid", 64'(deq_valid), 64'd0);
    fin();
    idle_inputs(); deq_ready = 1;
    half();
    chk("t6_next_valid", 64'(deq_valid), 64'd1);
    chk("t6_next_pc", 64'(deq_pc), 64'h80);
    fin();
`endif

    // Randomized traffic including held mispredicts and mid-run resets
    begin
      int mp_hold = 0;
      for (int c = 0; c < 3000; c++) begin
        idle_inputs();
        enq_valid        = ($urandom_range(0, 9) < 7);
        deq_ready        = ($urandom_range(0, 9) < ((c / 500) % 2 ? 3 : 7));
        enq_pc           = $urandom & 32'hffff_fff8;
        enq_inst1        = $urandom;
        enq_inst2        = $urandom;
        enq_slot_valid1  = ($urandom_range(0, 9) < 8);
        enq_slot_valid2  = ($urandom_range(0, 9) < 7);
        enq_pred_taken1  = ($urandom_range(0, 9) < 3);
        enq_pred_taken2  = ($urandom_range(0, 9) < 3);
        enq_pred_target1 = $urandom;
        enq_pred_target2 = $urandom;
        if (mp_hold > 0) begin
          mispredict = 1; mp_hold--;
        end else if ($urandom_range(0, 39) == 0) begin
          mispredict = 1; mp_hold = $urandom_range(0, 3);
        end
        reset = ($urandom_range(0, 299) == 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
